if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/rv32_pkg.sv | 19 +
 rtl/if_id_buffer.sv | 105 ++++++++++
 tb/tb_if_id_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions.
//   NOP_INSTR           : canonical NOP (addi x0, x0, 0), shown when a stage is empty
//   DEFAULT_INSTRUCTION : default instruction width in bits
//   DEFAULT_ADDRESS     : default PC width in bits
//   if_id_entry_t       : one IF/ID buffer entry {instruction, pc, pre_pc}
package rv32_pkg;

  localparam int DEFAULT_INSTRUCTION = 32;
  localparam int DEFAULT_ADDRESS     = 32;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [DEFAULT_INSTRUCTION-1:0] instruction;
    logic [DEFAULT_ADDRESS-1:0]     pc;
    logic [DEFAULT_ADDRESS-1:0]     pre_pc;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a 2-entry FIFO between fetch and decode.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   in_valid         : fetch presents {in_instruction, in_pc, in_pre_pc}
//   in_ready         : buffer can accept an entry (registered state only)
//   out_valid        : head entry is valid for decode
//   out_ready        : decode consumes the head this cycle
//   out_instruction,
//   out_pc, out_pre_pc : head entry fields (NOP/0/0 when empty)
//   flush            : discard all buffered entries (redirect)
//   count            : occupancy, 0..2
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and in_ready depends only on the
// registered occupancy, so neither out_ready nor flush reaches in_ready.
module if_id_buffer
  import rv32_pkg::*;
#(
  parameter int INSTRUCTION = DEFAULT_INSTRUCTION,
  parameter int ADDRESS     = DEFAULT_ADDRESS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [INSTRUCTION-1:0] in_instruction,
  input  logic [ADDRESS-1:0]     in_pc,
  input  logic [ADDRESS-1:0]     in_pre_pc,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTRUCTION-1:0] out_instruction,
  output logic [ADDRESS-1:0]     out_pc,
  output logic [ADDRESS-1:0]     out_pre_pc,
  input  logic                   flush,
  output logic [1:0]             count
);

  localparam logic [INSTRUCTION-1:0] NOP_W = INSTRUCTION'(NOP_INSTR);

  logic [INSTRUCTION-1:0] instr_mem  [2];
  logic [ADDRESS-1:0]     pc_mem     [2];
  logic [ADDRESS-1:0]     pre_pc_mem [2];

  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] occ;
  logic       push;
  logic       pop;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign count     = occ;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Head is always the read-pointer slot; an empty buffer shows a NOP so
  // decode never sees stale data even if it ignores out_valid.
  always_comb begin
    out_instruction = NOP_W;
    out_pc          = '0;
    out_pre_pc      = '0;
    if (occ != 2'd0) begin
      out_instruction = instr_mem[rd_ptr];
      out_pc          = pc_mem[rd_ptr];
      out_pre_pc      = pre_pc_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        instr_mem[i]  <= NOP_W;
        pc_mem[i]     <= '0;
        pre_pc_mem[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as is: with occ == 0 it is never shown.
      occ    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr]  <= in_instruction;
        pc_mem[wr_ptr]     <= in_pc;
        pre_pc_mem[wr_ptr] <= in_pre_pc;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // push is gated by occ != 2 and pop by occ != 0, so no wrap either way.
      if (push && !pop) begin
        occ <= occ + 2'd1;
      end else if (pop && !push) begin
        occ <= occ - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed testbench for if_id_buffer. Inputs are driven and outputs sampled
// on the falling edge; the DUT updates on the rising edge.
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h00000013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instruction = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_pre_pc = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [31:0] out_pre_pc;
  logic        flush = 1'b0;
  logic [1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  if_id_buffer #(.INSTRUCTION(32), .ADDRESS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instruction(in_instruction),
    .in_pc(in_pc), .in_pre_pc(in_pre_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc), .out_pre_pc(out_pre_pc),
    .flush(flush), .count(count)
  );

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  function automatic logic [31:0] pre_of(logic [31:0] pc);
    return pc + 32'h0000_1000;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid       = v;
    in_pc          = pc;
    in_instruction = instr_of(pc);
    in_pre_pc      = pre_of(pc);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h100);
    step();
    step();
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_instruction !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", out_instruction, NOP); end
    n_checks++; if (out_pc !== 32'h0 || out_pre_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h/%h want 0/0", out_pc, out_pre_pc); end
    rst = 1'b0;
    drive(1'b0, 32'h0);
  endtask

  task automatic test_fill_stall();
    out_ready = 1'b0;
    drive(1'b1, 32'h0);
    step();
    n_checks++; if (count !== 2'd1 || out_pc !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_first: got count %0d pc %h valid %b want 1 0 1", count, out_pc, out_valid); end
    n_checks++; if (out_instruction !== instr_of(32'h0) || out_pre_pc !== pre_of(32'h0)) begin n_fail++; $display("FAIL fill_fields: got %h/%h want %h/%h", out_instruction, out_pre_pc, instr_of(32'h0), pre_of(32'h0)); end
    drive(1'b1, 32'h4);
    step();
    n_checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got count %0d in_ready %b want 2 0", count, in_ready); end
    drive(1'b1, 32'h8);
    step();
    n_checks++; if (count !== 2'd2 || out_pc !== 32'h0) begin n_fail++; $display("FAIL stall_hold: got count %0d pc %h want 2 0", count, out_pc); end
    drive(1'b0, 32'h0);
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    n_checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_head0: got pc %h valid %b want 0 1", out_pc, out_valid); end
    step();
    n_checks++; if (out_pc !== 32'h4 || count !== 2'd1 || out_instruction !== instr_of(32'h4)) begin n_fail++; $display("FAIL drain_head1: got pc %h count %0d instr %h want 4 1 %h", out_pc, count, out_instruction, instr_of(32'h4)); end
    step();
    n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin n_fail++; $display("FAIL drain_empty: got valid %b count %0d want 0 0", out_valid, count); end
    n_checks++; if (out_instruction !== NOP || out_pc !== 32'h0) begin n_fail++; $display("FAIL drain_nop: got %h pc %h want %h 0", out_instruction, out_pc, NOP); end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] pc;
    logic [31:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pc = 32'h40 + 32'(i * 4);
      drive(1'b1, pc);
      if (in_ready === 1'b1) exp_q.push_back(pc);
      step();
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_checks++; if (out_pc !== exp || out_valid !== 1'b1 || out_pre_pc !== pre_of(exp)) begin n_fail++; $display("FAIL stream_head[%0d]: got pc %h valid %b pre %h want %h 1 %h", i, out_pc, out_valid, out_pre_pc, exp, pre_of(exp)); end
      n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d want 1", i, count); end
    end
    drive(1'b0, 32'h0);
    step();
    n_checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end: got count %0d valid %b want 0 0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Full buffer: a pop with in_valid high must not also push.
    out_ready = 1'b0;
    drive(1'b1, 32'h50); step();
    drive(1'b1, 32'h54); step();
    out_ready = 1'b1;
    drive(1'b1, 32'h58);
    step();
    n_checks++; if (count !== 2'd1 || out_pc !== 32'h54) begin n_fail++; $display("FAIL full_pop_no_push: got count %0d pc %h want 1 54", count, out_pc); end
    drive(1'b0, 32'h0);
    step();
    n_checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_drain: got count %0d valid %b want 0 0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h10); step();
    drive(1'b1, 32'h14); step();
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL flush_pre: got count %0d want 2", count); end
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h20);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    n_checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_clear: got count %0d valid %b in_ready %b want 0 0 1", count, out_valid, in_ready); end
    n_checks++; if (out_pc !== 32'h0 || out_instruction !== NOP) begin n_fail++; $display("FAIL flush_nop: got pc %h instr %h want 0 %h", out_pc, out_instruction, NOP); end
    step();
    n_checks++; if (out_valid !== 1'b0 || out_pc === 32'h20) begin n_fail++; $display("FAIL flush_no_ghost: got valid %b pc %h want 0 not 20", out_valid, out_pc); end
    // After flush the pointers restart: a fresh push must become the head.
    drive(1'b1, 32'h30);
    out_ready = 1'b0;
    step();
    drive(1'b0, 32'h0);
    n_checks++; if (out_pc !== 32'h30 || count !== 2'd1) begin n_fail++; $display("FAIL flush_restart: got pc %h count %0d want 30 1", out_pc, count); end
  endtask

  task automatic test_reset_mid();
    // Buffer holds 0x30 (count 1); rst wins over flush, push and pop.
    rst = 1'b1;
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h70);
    step();
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0);
    n_checks++; if (count !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got count %0d in_ready %b valid %b want 0 1 0", count, in_ready, out_valid); end
    n_checks++; if (out_instruction !== NOP || out_pc !== 32'h0 || out_pre_pc !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h %h %h want %h 0 0", out_instruction, out_pc, out_pre_pc, NOP); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_fill_stall();
    test_drain();
    test_streaming();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
